// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: sequences core reset, runs, stops on halt/budget.
// Optional pc-stall detection is enabled with `define MIPS_RUN_CTRL_STALL_DETECT_EN.
module mips_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 32,
    parameter int unsigned CNT_W       = 16,
    parameter logic [31:0] HALT_INSTR  = 32'h0000000C,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE, S_TOUT} state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             core_reset_q, core_reset_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             stall_hit;

`ifdef MIPS_RUN_CTRL_STALL_DETECT_EN
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

    logic [31:0]   prev_pc_q;
    logic [SW-1:0] same_q, same_d;

    // same_q counts consecutive RUN cycles that have shown the current pc; zero means no history.
    always_comb begin
        same_d    = same_q;
        stall_hit = 1'b0;
        if (state_q == S_HOLD) begin
            same_d = '0;
        end else if (state_q == S_RUN) begin
            same_d    = (same_q != '0 && pc == prev_pc_q) ? same_q + 1'b1 : SW'(1);
            stall_hit = (same_d == SW'(STALL_LIMIT));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) same_q <= '0;
        else       same_q <= same_d;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_RUN) prev_pc_q <= pc;
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = count_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start) begin
                    state_d   = S_HOLD;
                    hold_d    = HW'(RST_CYCLES - 1);
                    count_d   = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_RUN;
                else              hold_d  = hold_q - 1'b1;
            end
            S_RUN: begin
                // The final cycle is counted too, so a halt on cycle N reports N.
                count_d = count_q + 1'b1;
                if (instr == HALT_INSTR || stall_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (count_d == CNT_W'(MAX_CYCLES)) begin
                    state_d   = S_TOUT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        core_reset_d = (state_d != S_RUN);
        running_d    = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            count_q      <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            count_q      <= count_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;

endmodule
